// File: rtl/elastic_ring.sv
// ----------------------------------------------------------------------------
// elastic_ring
// RING_DEPTH-entry circular storage for the elastic buffer. The parent
// guarantees it never writes when full nor reads when empty, so the ring
// keeps no occupancy of its own - only the two pointers.
//
// Parameters:
//   WORD_WIDTH  - data word width
//   RING_DEPTH  - number of entries (>=1, any integer)
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset (pointers only)
//   i_clear    in   synchronous pointer reset, overrides read and write
//   i_wr_en    in   store i_wr_data at the write pointer and advance it
//   i_wr_data  in   word to store
//   i_rd_en    in   advance the read pointer (head consumed)
//   o_rd_data  out  current head word (combinational read)
// ----------------------------------------------------------------------------
module elastic_ring #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned RING_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_wr_en,
  input  logic [WORD_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  output logic [WORD_WIDTH-1:0] o_rd_data
);

  localparam int unsigned PTR_WIDTH = (RING_DEPTH > 1) ? $clog2(RING_DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(RING_DEPTH - 1);

  logic [WORD_WIDTH-1:0] r_mem [RING_DEPTH];
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;

  // Depth need not be a power of two, so wrap by explicit compare.
  function automatic logic [PTR_WIDTH-1:0] f_next(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == LAST_IDX) ? '0 : ptr + PTR_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= f_next(r_wr_ptr);
      if (i_rd_en) r_rd_ptr <= f_next(r_rd_ptr);
    end
  end

  // NOTE: storage deliberately has no reset; a slot is only ever read after
  // it has been written, so resetting the array would buy nothing.
  always_ff @(posedge clk) begin
    if (i_wr_en && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];

endmodule

// File: rtl/register.sv
// ----------------------------------------------------------------------------
// register
// Generic enabled flop bank with asynchronous active-high reset.
//
// Parameters:
//   WIDTH        - number of bits
//   RESET_VALUE  - value loaded while reset is high
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset
//   i_clk_en  in   load enable; o_q holds when low
//   i_d       in   next value
//   o_q       out  registered value
// ----------------------------------------------------------------------------
module register #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clk_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // NOTE: non-blocking assignment so every flop in the design samples
  // pre-edge values and the evaluation order of processes cannot matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_q <= RESET_VALUE;
    end else if (i_clk_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/elastic_buffer.sv
// ----------------------------------------------------------------------------
// elastic_buffer
// Ready/valid elastic buffer of DEPTH words: one output register holding the
// oldest word plus a (DEPTH-1)-entry ring for the rest. i_ready, o_valid,
// o_data, o_count and o_almost_full are all registered, so there is no
// combinational path between the upstream and downstream handshakes.
//
// Parameters:
//   WORD_WIDTH         - data word width (>=1)
//   DEPTH              - total capacity incl. output register (>=2)
//   ALMOST_FULL_LEVEL  - occupancy at/above which o_almost_full is set
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   i_clear        in   synchronous flush; beats insert and remove
//   i_valid        in   upstream word valid
//   i_ready        out  buffer accepts a word this cycle
//   i_data         in   upstream word
//   o_valid        out  o_data holds the oldest word
//   o_ready        in   downstream accepts
//   o_data         out  oldest word
//   o_count        out  occupancy 0..DEPTH
//   o_almost_full  out  o_count >= ALMOST_FULL_LEVEL
// ----------------------------------------------------------------------------
module elastic_buffer #(
  parameter  int unsigned WORD_WIDTH        = 8,
  parameter  int unsigned DEPTH             = 4,
  parameter  int unsigned ALMOST_FULL_LEVEL = DEPTH - 1,
  localparam int unsigned COUNT_WIDTH       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clear,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [WORD_WIDTH-1:0]  i_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [WORD_WIDTH-1:0]  o_data,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_almost_full
);

  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] AF_COUNT   = COUNT_WIDTH'(ALMOST_FULL_LEVEL);

  logic                   w_insert;
  logic                   w_remove;
  logic                   w_ring_empty;
  logic                   w_load;
  logic                   w_rd_en;
  logic                   w_wr_en;
  logic                   w_data_en;
  logic [WORD_WIDTH-1:0]  w_data_next;
  logic [WORD_WIDTH-1:0]  w_ring_data;
  logic [COUNT_WIDTH-1:0] w_count_next;

  assign w_insert = i_valid & i_ready;
  assign w_remove = o_valid & o_ready;
  // The output register holds one word whenever count > 0, so the ring
  // holds count-1 words and is empty for count 0 or 1.
  assign w_ring_empty = (o_count < COUNT_WIDTH'(2));
  assign w_load       = !o_valid | w_remove;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    w_data_en    = 1'b0;
    w_data_next  = i_data;
    w_count_next = o_count + COUNT_WIDTH'(w_insert) - COUNT_WIDTH'(w_remove);

    if (i_clear) begin
      w_count_next = '0;
    end else begin
      if (w_load && !w_ring_empty) begin
        // Refill the output register from the ring head.
        w_rd_en     = 1'b1;
        w_data_en   = 1'b1;
        w_data_next = w_ring_data;
      end else if (w_load && w_insert) begin
        // Ring empty: bypass straight into the output register.
        w_data_en   = 1'b1;
      end
      // Any insert that did not go to the output register lands in the ring.
      w_wr_en = w_insert && !(w_load && w_ring_empty);
    end
  end

  elastic_ring #(
    .WORD_WIDTH (WORD_WIDTH),
    .RING_DEPTH (DEPTH - 1)
  ) u_ring (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (i_clear),
    .i_wr_en   (w_wr_en),
    .i_wr_data (i_data),
    .i_rd_en   (w_rd_en),
    .o_rd_data (w_ring_data)
  );

  register #(.WIDTH(WORD_WIDTH), .RESET_VALUE('0)) u_data_reg (
    .clk (clk), .reset (reset), .i_clk_en (w_data_en),
    .i_d (w_data_next), .o_q (o_data)
  );

  register #(.WIDTH(COUNT_WIDTH), .RESET_VALUE('0)) u_count_reg (
    .clk (clk), .reset (reset), .i_clk_en (1'b1),
    .i_d (w_count_next), .o_q (o_count)
  );

  register #(.WIDTH(1), .RESET_VALUE(1'b1)) u_ready_reg (
    .clk (clk), .reset (reset), .i_clk_en (1'b1),
    .i_d (w_count_next != FULL_COUNT), .o_q (i_ready)
  );

  register #(.WIDTH(1), .RESET_VALUE(1'b0)) u_valid_reg (
    .clk (clk), .reset (reset), .i_clk_en (1'b1),
    .i_d (w_count_next != '0), .o_q (o_valid)
  );

  register #(.WIDTH(1), .RESET_VALUE(1'b0)) u_af_reg (
    .clk (clk), .reset (reset), .i_clk_en (1'b1),
    .i_d (w_count_next >= AF_COUNT), .o_q (o_almost_full)
  );

`ifdef FORMAL
  a_count_max: assert property (@(posedge clk) disable iff (reset)
    o_count <= FULL_COUNT);
  a_valid_count: assert property (@(posedge clk) disable iff (reset)
    o_valid == (o_count != '0));
  a_ready_count: assert property (@(posedge clk) disable iff (reset)
    i_ready == (o_count != FULL_COUNT));
  a_count_step: assert property (@(posedge clk) disable iff (reset)
    !$past(i_clear) |-> (o_count == $past(o_count)) ||
                        (o_count == $past(o_count) + COUNT_WIDTH'(1)) ||
                        (o_count + COUNT_WIDTH'(1) == $past(o_count)));
  m_upstream_hold: assume property (@(posedge clk) disable iff (reset)
    (i_valid && !i_ready) |=> (i_valid && $stable(i_data)));
`endif

endmodule

// File: tb/tb_elastic_buffer.sv
// ----------------------------------------------------------------------------
// tb_elastic_buffer
// Two DUTs share one stimulus stream: u_dut4 (defaults, DEPTH=4) is used for
// the directed fill/drain/stream/clear/reset phases, u_dut5 (DEPTH=5) for the
// randomized wrap/order phase. The reference model is a plain queue: its
// size is the occupancy and its head is the word that must be on o_data.
// ----------------------------------------------------------------------------
module tb_elastic_buffer;

  localparam int NUM_RANDOM = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_clear;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;

  logic       d4_i_ready, d4_o_valid, d4_af;
  logic [7:0] d4_o_data;
  logic [2:0] d4_count;
  logic       d5_i_ready, d5_o_valid, d5_af;
  logic [7:0] d5_o_data;
  logic [2:0] d5_count;

  elastic_buffer u_dut4 (
    .clk (clk), .reset (reset), .i_clear (i_clear),
    .i_valid (i_valid), .i_ready (d4_i_ready), .i_data (i_data),
    .o_valid (d4_o_valid), .o_ready (o_ready), .o_data (d4_o_data),
    .o_count (d4_count), .o_almost_full (d4_af)
  );

  elastic_buffer #(.DEPTH(5)) u_dut5 (
    .clk (clk), .reset (reset), .i_clear (i_clear),
    .i_valid (i_valid), .i_ready (d5_i_ready), .i_data (i_data),
    .o_valid (d5_o_valid), .o_ready (o_ready), .o_data (d5_o_data),
    .o_count (d5_count), .o_almost_full (d5_af)
  );

  always #5 clk = ~clk;

  // Selected DUT seen by the monitor.
  logic       sel;
  logic       m_i_ready, m_o_valid, m_af;
  logic [7:0] m_o_data;
  logic [2:0] m_count;
  assign m_i_ready = sel ? d5_i_ready : d4_i_ready;
  assign m_o_valid = sel ? d5_o_valid : d4_o_valid;
  assign m_af      = sel ? d5_af      : d4_af;
  assign m_o_data  = sel ? d5_o_data  : d4_o_data;
  assign m_count   = sel ? d5_count   : d4_count;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model / scoreboard.
  logic [7:0] q[$];
  int         depth = 4;
  int         afl   = 3;
  bit         last_ins;
  int         delivered;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      last_ins  = 1'b0;
      delivered = 0;
    end else begin
      bit ins;
      bit rem;
      ins = i_valid && (q.size() != depth);
      rem = (q.size() != 0) && o_ready;
      last_ins = ins && !i_clear;
      if (i_clear) begin
        q.delete();
      end else begin
        if (rem) begin
          void'(q.pop_front());
          delivered++;
        end
        if (ins) q.push_back(i_data);
      end
    end
  end

  // Monitor: compare the selected DUT against the model every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      check("o_count", 32'(m_count), q.size());
      check("o_valid", 32'(m_o_valid), 32'(q.size() != 0));
      check("i_ready", 32'(m_i_ready), 32'(q.size() != depth));
      check("o_almost_full", 32'(m_af), 32'(q.size() >= afl));
      if (q.size() != 0) check("o_data", 32'(m_o_data), 32'(q[0]));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int cyc;
    reset = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_data = '0; o_ready = 1'b0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_i_ready", 32'(d4_i_ready), 1);
    check("rst_o_valid", 32'(d4_o_valid), 0);
    check("rst_count",   32'(d4_count), 0);
    check("rst_o_data",  32'(d4_o_data), 0);
    check("rst_af",      32'(d4_af), 0);

    // Fill with downstream stalled, then offer more while full.
    for (int k = 1; k <= 4; k++) begin
      i_valid = 1'b1; i_data = 8'(k); step();
    end
    i_valid = 1'b1; i_data = 8'h55; step(); step();
    i_valid = 1'b0;
    check("full_count",   32'(d4_count), 4);
    check("full_i_ready", 32'(d4_i_ready), 0);
    check("full_o_data",  32'(d4_o_data), 8'h01);

    // Drain.
    o_ready = 1'b1;
    repeat (5) step();
    check("drained_o_valid", 32'(d4_o_valid), 0);
    check("drained_i_ready", 32'(d4_i_ready), 1);

    // Streaming: one word per cycle, one cycle latency.
    for (int k = 0; k < 16; k++) begin
      i_valid = 1'b1; i_data = 8'(8'h10 + k); step();
      check("stream_count",  32'(d4_count), 1);
      check("stream_o_data", 32'(d4_o_data), 32'(8'h10 + k));
    end
    i_valid = 1'b0; step();

    // Clear at count=3 with a simultaneous insert and remove.
    o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_data = 8'(8'hA1 + k); step();
    end
    check("pre_clear_count", 32'(d4_count), 3);
    i_clear = 1'b1; i_valid = 1'b1; i_data = 8'hEE; o_ready = 1'b1; step();
    i_clear = 1'b0; i_valid = 1'b0;
    check("clear_count",   32'(d4_count), 0);
    check("clear_o_valid", 32'(d4_o_valid), 0);
    check("clear_i_ready", 32'(d4_i_ready), 1);
    check("clear_af",      32'(d4_af), 0);
    i_valid = 1'b1; i_data = 8'h33; step();
    i_valid = 1'b0;
    check("post_clear_o_data", 32'(d4_o_data), 8'h33);
    step();

    // Reset mid-stream at count=3.
    o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_data = 8'(8'hC1 + k); step();
    end
    i_valid = 1'b0;
    check("pre_rst_count", 32'(d4_count), 3);
    reset = 1'b1;
    #1;
    check("mid_rst_i_ready", 32'(d4_i_ready), 1);
    check("mid_rst_o_valid", 32'(d4_o_valid), 0);
    check("mid_rst_count",   32'(d4_count), 0);
    check("mid_rst_o_data",  32'(d4_o_data), 0);

    // Random wrap/order phase on the DEPTH=5 instance.
    sel = 1'b1; depth = 5; afl = 4;
    step();
    reset = 1'b0;
    sent = 0;
    cyc  = 0;
    while (sent < NUM_RANDOM && cyc < 20000) begin
      step();
      cyc++;
      if (i_valid && last_ins) sent++;
      if (!i_valid || last_ins) begin
        if (sent < NUM_RANDOM && $urandom_range(0, 1) == 1) begin
          i_valid = 1'b1;
          i_data  = 8'(sent);
        end else begin
          i_valid = 1'b0;
        end
      end
      o_ready = ($urandom_range(0, 1) == 1);
    end
    check("random_all_sent", sent, NUM_RANDOM);
    i_valid = 1'b0; o_ready = 1'b1;
    repeat (20) step();
    check("random_delivered", delivered, NUM_RANDOM);
    check("random_final_count", 32'(d5_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elastic_buffer.md
Name: elastic_buffer

Overview:
Parametrised-depth successor to the 2-entry skid buffer. It is a ready/valid elastic buffer holding up to DEPTH words: one output register plus a (DEPTH-1)-entry ring buffer. i_ready, o_valid and o_data are all registered, so neither side sees a combinational path. It adds occupancy reporting, an almost-full flag and a synchronous clear, and sits wherever the datapath needs more than 2 words of slack between pipeline stages.

Parameters:
WORD_WIDTH, 8, data word width (>=1)
DEPTH, 4, total capacity in words, including the output register (>=2; any integer, power of two not required)
ALMOST_FULL_LEVEL, DEPTH-1, occupancy at or above which o_almost_full asserts (1..DEPTH)
COUNT_WIDTH (localparam), $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
i_clear  in  1  synchronous flush of all contents
i_valid  in  1  upstream word valid
i_ready  out  1  registered; buffer can accept a word this cycle
i_data  in  WORD_WIDTH  upstream data
o_valid  out  1  registered; o_data holds the oldest word
o_ready  in  1  downstream accepts
o_data  out  WORD_WIDTH  registered oldest word
o_count  out  COUNT_WIDTH  registered occupancy, 0..DEPTH
o_almost_full  out  1  registered; o_count >= ALMOST_FULL_LEVEL

Behaviour:
- Reset (async assert, sync release): i_ready=1, o_valid=0, o_data=0, o_count=0, o_almost_full=0, ring pointers=0. Reset mid-operation discards all contents.
- insert = i_valid & i_ready; remove = o_valid & o_ready.
- count_next = count + insert - remove. Registered outputs derive from count_next:
  - i_ready <= (count_next != DEPTH)
  - o_valid <= (count_next != 0)
  - o_almost_full <= (count_next >= ALMOST_FULL_LEVEL)
- Invariant: when count>0, the output register holds the oldest word and the ring holds the remaining count-1 words in order.
- Output register load, when (!o_valid | remove):
  - ring non-empty: load the ring head and advance the read pointer.
  - ring empty and insert: load i_data directly (bypass; latency 1 cycle from insert to o_valid).
  - otherwise: hold.
- Ring write: on an insert that does not bypass, write i_data at the write pointer and advance it.
- Pointer wrap: each pointer returns to 0 after index DEPTH-2, using an explicit compare. Simultaneous ring read and write is allowed in the same cycle.
- Full (count=DEPTH): i_ready=0. Asserting i_valid while full has no effect. If remove occurs while full, i_ready returns to 1 the next cycle.
- Simultaneous insert and remove at count=DEPTH cannot occur, because i_ready is already 0.
- At count=1 with insert & remove: bypass, o_valid stays 1, throughput is 1 word/cycle.
- Stability: while o_valid & !o_ready, o_data and o_valid hold.
- Upstream obligation, asserted in the formal build: while i_valid & !i_ready, i_valid stays high and i_data stays stable.
- i_clear has priority over insert and remove in the same cycle:
  - the insert is dropped and the remove is not honoured;
  - next cycle: count=0, o_valid=0, i_ready=1, o_almost_full=0, pointers=0;
  - o_data keeps its value (don't-care).
- Formal checks:
  - o_count <= DEPTH;
  - o_valid == (o_count != 0);
  - i_ready == (o_count != DEPTH);
  - |o_count step| <= 1 except on clear or reset.

Decomposition:
- No shared package is needed. COUNT_WIDTH and pointer widths are local.
- All flops on the reset domain use the existing register module (clk_en, reset, RESET_VALUE): output data, i_ready, o_valid, count, almost_full.
- One sub-module, elastic_ring: a (DEPTH-1)-entry storage array with write and read pointers plus wrap. Ports: clk, reset, clear, wr_en, wr_data, rd_en, rd_data. Storage has no reset; pointers reset to 0.

Test Plan:
- Reset: assert reset mid-stream with count=3 -> outputs immediately i_ready=1, o_valid=0, o_count=0, o_data=0.
- Fill (DEPTH=4, ALMOST_FULL_LEVEL=3, o_ready=0): push 0x01..0x04 on consecutive cycles -> o_count 1,2,3,4; o_almost_full rises the cycle after the 3rd push; i_ready=0 the cycle after the 4th push; o_data stays 0x01.
- Drain from full with o_ready=1 -> o_data 0x01,0x02,0x03,0x04 on consecutive cycles; i_ready=1 one cycle after the first remove; o_valid=0 after the 4th.
- Streaming: i_valid=o_ready=1 for 16 cycles with 0x10..0x1F -> o_data equals the input delayed by 1 cycle; o_count stays 1; no bubbles.
- Wrap/order (DEPTH=5): 1000 incrementing words with random 50% stalls on both sides -> scoreboard shows in-order delivery with no loss or duplication; o_count matches the model every cycle.
- Clear: at count=3, assert i_clear with i_valid=o_ready=1 -> next cycle o_count=0, o_valid=0, i_ready=1; the inserted word never appears at the output.
